// File: rtl/flit_sink_pkg.sv
// Shared flit-interface definitions: flit type codes, error codes, tracker states
// and interface width defaults for the receive-side monitor.
package flit_sink_pkg;

    localparam int FLIT_W_DEF  = 66;
    localparam int VCH_W_DEF   = 1;
    localparam int LEN_W_DEF   = 8;
    localparam int MAX_LEN_DEF = 255;

    typedef enum logic [1:0] {
        TYPE_NONE = 2'b00,
        TYPE_HEAD = 2'b01,
        TYPE_TAIL = 2'b10,
        TYPE_DATA = 2'b11
    } flit_type_t;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_ORPHAN = 3'd1,
        ERR_NESTED = 3'd2,
        ERR_NULL   = 3'd3,
        ERR_LEN    = 3'd4
    } err_code_t;

    typedef enum logic {
        VC_IDLE = 1'b0,
        VC_BODY = 1'b1
    } vc_state_t;

    // Saturating 32-bit add: clamps at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/flit_sink_vc_tracker.sv
// One virtual channel's packet framing tracker: IDLE/BODY state, DATA length
// counter and per-VC framing error detection for the flit currently presented.
module flit_vc_tracker
    import flit_sink_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             sel,
    input  flit_type_t       ftype,
    output logic             done,
    output logic [LEN_W-1:0] len,
    output err_code_t        err_ev
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    vc_state_t        state;
    vc_state_t        state_d;
    logic [LEN_W-1:0] len_d;

    // Events and next state for the flit on this VC; non-selected VCs hold still.
    always_comb begin
        state_d = state;
        len_d   = len;
        done    = 1'b0;
        err_ev  = ERR_NONE;
        if (sel) begin
            case (ftype)
                TYPE_NONE: begin
                    err_ev = ERR_NULL;
                end
                TYPE_HEAD: begin
                    if (state == VC_BODY) begin
                        err_ev = ERR_NESTED;
                    end
                    state_d = VC_BODY;
                    len_d   = '0;
                end
                TYPE_DATA: begin
                    if (state == VC_IDLE) begin
                        err_ev = ERR_ORPHAN;
                    end else if (len == MAX_L) begin
                        err_ev = ERR_LEN;
                    end else begin
                        len_d = len + 1'b1;
                    end
                end
                TYPE_TAIL: begin
                    if (state == VC_IDLE) begin
                        err_ev = ERR_ORPHAN;
                    end else begin
                        state_d = VC_IDLE;
                        done    = 1'b1;
                    end
                end
                default: begin
                    err_ev = ERR_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= VC_IDLE;
            len   <= '0;
        end else begin
            state <= state_d;
            len   <= len_d;
        end
    end

endmodule

// File: rtl/flit_sink.sv
// Receive-side flit monitor: per-VC packet reconstruction, packet/flit counters,
// first-error capture and data-bus toggle accumulation inside a measurement window.
module flit_sink
    import flit_sink_pkg::*;
#(
    parameter int FLIT_W  = FLIT_W_DEF,
    parameter int VCH_W   = VCH_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [FLIT_W-1:0] idata,
    input  logic              ivalid,
    input  logic [VCH_W-1:0]  ivch,
    input  logic              en,
    input  logic              clr,
    output logic              pkt_done,
    output logic [VCH_W-1:0]  pkt_vch,
    output logic [LEN_W-1:0]  last_len,
    output logic [15:0]       pkt_cnt,
    output logic [31:0]       flit_cnt,
    output logic [31:0]       toggle_sum,
    output logic              err,
    output logic [2:0]        err_code
);

    localparam int NVC  = 2 ** VCH_W;
    localparam int PC_W = $clog2(FLIT_W + 1);

    flit_type_t       ftype;
    logic [NVC-1:0]   vc_sel;
    logic [NVC-1:0]   vc_done;
    logic [LEN_W-1:0] vc_len [NVC];
    err_code_t        vc_err [NVC];

    logic             ev_done;
    logic [LEN_W-1:0] ev_len;
    err_code_t        ev_err;
    err_code_t        err_q;

    logic [FLIT_W-1:0] prev_data;
    logic [FLIT_W-1:0] diff;
    logic [PC_W-1:0]   pop;

    assign ftype = flit_type_t'(idata[FLIT_W-1 -: 2]);

    for (genvar v = 0; v < NVC; v++) begin : g_vc
        assign vc_sel[v] = ivalid && (ivch == VCH_W'(v));

        flit_vc_tracker #(
            .LEN_W   (LEN_W),
            .MAX_LEN (MAX_LEN)
        ) u_tracker (
            .clk    (clk),
            .rst_   (rst_),
            .sel    (vc_sel[v]),
            .ftype  (ftype),
            .done   (vc_done[v]),
            .len    (vc_len[v]),
            .err_ev (vc_err[v])
        );
    end

    assign ev_done = vc_done[ivch];
    assign ev_len  = vc_len[ivch];

    // Lowest-numbered VC reporting an error wins; only one VC is selected per cycle.
    always_comb begin
        ev_err = ERR_NONE;
        for (int v = 0; v < NVC; v++) begin
            if (ev_err == ERR_NONE && vc_err[v] != ERR_NONE) begin
                ev_err = vc_err[v];
            end
        end
    end

    always_comb begin
        diff = idata ^ prev_data;
        pop  = '0;
        for (int i = 0; i < FLIT_W; i++) begin
            pop = pop + PC_W'(diff[i]);
        end
    end

    // Completion reporting and the toggle reference run regardless of en and clr.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pkt_done  <= 1'b0;
            pkt_vch   <= '0;
            last_len  <= '0;
            prev_data <= '0;
        end else begin
            pkt_done  <= ev_done;
            prev_data <= idata;
            if (ev_done) begin
                pkt_vch  <= ivch;
                last_len <= ev_len;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pkt_cnt    <= '0;
            flit_cnt   <= '0;
            toggle_sum <= '0;
        end else if (clr) begin
            pkt_cnt    <= '0;
            flit_cnt   <= '0;
            toggle_sum <= '0;
        end else if (en) begin
            if (ivalid && flit_cnt != 32'hFFFF_FFFF) begin
                flit_cnt <= flit_cnt + 32'd1;
            end
            if (ev_done && pkt_cnt != 16'hFFFF) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            toggle_sum <= sat_add32(toggle_sum, 32'(pop));
        end
    end

    // Only the first error after reset/clr is recorded.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            err   <= 1'b0;
            err_q <= ERR_NONE;
        end else if (clr) begin
            err   <= 1'b0;
            err_q <= ERR_NONE;
        end else if (!err && ev_err != ERR_NONE) begin
            err   <= 1'b1;
            err_q <= ev_err;
        end
    end

    assign err_code = err_q;

endmodule

// File: tb/tb_flit_sink.sv
// Bench for flit_sink: two instances (MAX_LEN 255 and 16) driven in parallel,
// checked against a packet-level reference model, table vectors and directed sequences.
module tb_flit_sink;
    import flit_sink_pkg::*;

    localparam int FW = 66;

    logic          clk = 1'b0;
    logic          rst_;
    logic [FW-1:0] idata;
    logic          ivalid;
    logic [0:0]    ivch;
    logic          en;
    logic          clr;

    logic        done_a, done_b;
    logic [0:0]  vch_a, vch_b;
    logic [7:0]  last_a, last_b;
    logic [15:0] pkt_a, pkt_b;
    logic [31:0] flit_a, flit_b;
    logic [31:0] tog_a, tog_b;
    logic        err_a, err_b;
    logic [2:0]  code_a, code_b;

    flit_sink #(.FLIT_W(FW), .VCH_W(1), .LEN_W(8), .MAX_LEN(255)) dut_a (
        .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .en(en), .clr(clr), .pkt_done(done_a), .pkt_vch(vch_a), .last_len(last_a),
        .pkt_cnt(pkt_a), .flit_cnt(flit_a), .toggle_sum(tog_a), .err(err_a),
        .err_code(code_a)
    );

    flit_sink #(.FLIT_W(FW), .VCH_W(1), .LEN_W(8), .MAX_LEN(16)) dut_b (
        .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .en(en), .clr(clr), .pkt_done(done_b), .pkt_vch(vch_b), .last_len(last_b),
        .pkt_cnt(pkt_b), .flit_cnt(flit_b), .toggle_sum(tog_b), .err(err_b),
        .err_code(code_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state, index k selects the instance (0: MAX_LEN 255, 1: MAX_LEN 16).
    int     m_max [2] = '{255, 16};
    bit     m_in  [2][2];
    int     m_len [2][2];
    bit     e_done [2];
    int     e_vch  [2];
    int     e_last [2];
    longint e_pkt  [2];
    longint e_flit [2];
    longint e_tog  [2];
    bit     e_err  [2];
    int     e_code [2];
    logic [FW-1:0] m_prev;

    typedef struct {
        bit       valid;
        bit       vch;
        logic [1:0] ftype;
        bit       en;
        bit       clr;
        bit       exp_done;
        bit       exp_vch;
        int       exp_last;
        bit       exp_err;
        int       exp_code;
    } vec_t;

    vec_t tbl [22];

    task automatic check_val(input string name, input int k, input logic [63:0] got,
                             input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d got=%0h exp=%0h t=%0t", name, k, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int v = 0; v < 2; v++) begin
                m_in[k][v]  = 1'b0;
                m_len[k][v] = 0;
            end
            e_done[k] = 0; e_vch[k] = 0; e_last[k] = 0;
            e_pkt[k] = 0; e_flit[k] = 0; e_tog[k] = 0;
            e_err[k] = 0; e_code[k] = 0;
        end
        m_prev = '0;
    endtask

    task automatic model_step();
        int t;
        int v;
        int newerr;
        int toggles;
        t       = int'(idata[FW-1 -: 2]);
        v       = int'(ivch);
        toggles = $countones(idata ^ m_prev);
        for (int k = 0; k < 2; k++) begin
            newerr    = 0;
            e_done[k] = 0;
            if (ivalid) begin
                if (t == 0) begin
                    newerr = 3;
                end else if (t == 1) begin
                    if (m_in[k][v]) newerr = 2;
                    m_in[k][v]  = 1'b1;
                    m_len[k][v] = 0;
                end else if (t == 3) begin
                    if (!m_in[k][v]) newerr = 1;
                    else if (m_len[k][v] == m_max[k]) newerr = 4;
                    else m_len[k][v] = m_len[k][v] + 1;
                end else begin
                    if (!m_in[k][v]) newerr = 1;
                    else begin
                        m_in[k][v] = 1'b0;
                        e_done[k]  = 1;
                        e_vch[k]   = v;
                        e_last[k]  = m_len[k][v];
                    end
                end
            end
            if (en) begin
                if (ivalid && e_flit[k] < 64'hFFFF_FFFF) e_flit[k] = e_flit[k] + 1;
                if (e_done[k] && e_pkt[k] < 65535) e_pkt[k] = e_pkt[k] + 1;
                e_tog[k] = e_tog[k] + toggles;
                if (e_tog[k] > 64'hFFFF_FFFF) e_tog[k] = 64'hFFFF_FFFF;
            end
            if (newerr != 0 && !e_err[k]) begin
                e_err[k]  = 1;
                e_code[k] = newerr;
            end
            if (clr) begin
                e_pkt[k] = 0; e_flit[k] = 0; e_tog[k] = 0;
                e_err[k] = 0; e_code[k] = 0;
            end
        end
        m_prev = idata;
    endtask

    task automatic check_output();
        for (int k = 0; k < 2; k++) begin
            check_val("pkt_done",   k, k == 1 ? done_b : done_a, e_done[k]);
            check_val("pkt_vch",    k, k == 1 ? vch_b  : vch_a,  e_vch[k]);
            check_val("last_len",   k, k == 1 ? last_b : last_a, e_last[k]);
            check_val("pkt_cnt",    k, k == 1 ? pkt_b  : pkt_a,  e_pkt[k]);
            check_val("flit_cnt",   k, k == 1 ? flit_b : flit_a, e_flit[k]);
            check_val("toggle_sum", k, k == 1 ? tog_b  : tog_a,  e_tog[k]);
            check_val("err",        k, k == 1 ? err_b  : err_a,  e_err[k]);
            check_val("err_code",   k, k == 1 ? code_b : code_a, e_code[k]);
        end
    endtask

    function automatic logic [FW-1:0] make_flit(input logic [1:0] t);
        logic [63:0] p;
        p = {$urandom(), $urandom()};
        return {t, p};
    endfunction

    // Drive one cycle of inputs, advance the model on the edge, compare just after it.
    task automatic apply_stimulus(input bit v, input bit ch, input logic [FW-1:0] d,
                                  input bit e, input bit c);
        ivalid = v;
        ivch   = ch;
        idata  = d;
        en     = e;
        clr    = c;
        @(posedge clk);
        model_step();
        #1;
        check_output();
    endtask

    task automatic send(input bit ch, input logic [1:0] t, input bit c);
        apply_stimulus(1'b1, ch, make_flit(t), 1'b1, c);
    endtask

    task automatic idle_cycle(input bit e, input bit c);
        apply_stimulus(1'b0, 1'b0, make_flit(2'b00), e, c);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_   = 1'b0;
        idata  = '0;
        ivalid = 1'b0;
        ivch   = '0;
        en     = 1'b0;
        clr    = 1'b0;
        model_reset();
        #12;
        check_val("rst_done", 0, done_a, 0);
        check_val("rst_pkt",  0, pkt_a,  0);
        check_val("rst_flit", 0, flit_a, 0);
        check_val("rst_tog",  0, tog_a,  0);
        check_val("rst_err",  0, {err_a, code_a}, 0);
        check_val("rst_last", 0, last_a, 0);
        rst_ = 1'b1;

        // Packet on VC1 with 20 DATA; instance 1 (MAX_LEN 16) overflows its length.
        send(1'b1, TYPE_HEAD, 1'b0);
        for (int i = 0; i < 20; i++) send(1'b1, TYPE_DATA, 1'b0);
        send(1'b1, TYPE_TAIL, 1'b0);
        check_val("pkt1_done", 0, done_a, 1);
        check_val("pkt1_vch",  0, vch_a,  1);
        check_val("pkt1_last", 0, last_a, 20);
        check_val("pkt1_cnt",  0, pkt_a,  1);
        check_val("pkt1_flit", 0, flit_a, 22);
        check_val("pkt1_err",  0, err_a,  0);
        check_val("len_code",  1, code_b, 4);
        check_val("len_last",  1, last_b, 16);
        check_val("len_done",  1, done_b, 1);
        idle_cycle(1'b0, 1'b0);
        check_val("pkt1_pulse_end", 0, done_a, 0);

        // Toggle window: alternating all-zeros/all-ones bus, first with en high then low.
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, (i % 2 == 0) ? {FW{1'b1}} : '0, 1'b1, 1'b0);
        check_val("tog_en1", 0, tog_a, 264);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, (i % 2 == 0) ? {FW{1'b1}} : '0, 1'b0, 1'b0);
        check_val("tog_en0", 0, tog_a, 0);

        // Framing table: orphan, nested, null, first-error hold, interleaving, back-to-back.
        tbl[0]  = '{0, 0, TYPE_NONE, 1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, TYPE_DATA, 1, 0, 0, 0, 0, 1, 1};
        tbl[2]  = '{1, 0, TYPE_HEAD, 1, 0, 0, 0, 0, 1, 1};
        tbl[3]  = '{1, 0, TYPE_DATA, 1, 0, 0, 0, 0, 1, 1};
        tbl[4]  = '{1, 0, TYPE_HEAD, 1, 0, 0, 0, 0, 1, 1};
        tbl[5]  = '{1, 0, TYPE_NONE, 1, 0, 0, 0, 0, 1, 1};
        tbl[6]  = '{1, 0, TYPE_TAIL, 1, 0, 1, 0, 0, 1, 1};
        tbl[7]  = '{0, 0, TYPE_NONE, 1, 1, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 1, TYPE_NONE, 1, 0, 0, 0, 0, 1, 3};
        tbl[9]  = '{1, 1, TYPE_TAIL, 1, 0, 0, 0, 0, 1, 3};
        tbl[10] = '{0, 0, TYPE_NONE, 1, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 0, TYPE_HEAD, 1, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{1, 1, TYPE_HEAD, 1, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{1, 0, TYPE_DATA, 1, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{1, 1, TYPE_DATA, 1, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{1, 1, TYPE_DATA, 1, 0, 0, 0, 0, 0, 0};
        tbl[16] = '{1, 0, TYPE_TAIL, 1, 0, 1, 0, 1, 0, 0};
        tbl[17] = '{1, 1, TYPE_TAIL, 1, 0, 1, 1, 2, 0, 0};
        tbl[18] = '{1, 1, TYPE_HEAD, 1, 0, 0, 0, 0, 0, 0};
        tbl[19] = '{1, 1, TYPE_DATA, 1, 0, 0, 0, 0, 0, 0};
        tbl[20] = '{1, 1, TYPE_TAIL, 1, 0, 1, 1, 1, 0, 0};
        tbl[21] = '{0, 0, TYPE_NONE, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 22; i++) begin
            apply_stimulus(tbl[i].valid, tbl[i].vch, make_flit(tbl[i].ftype), tbl[i].en, tbl[i].clr);
            check_val("tbl_done", 0, done_a, tbl[i].exp_done);
            check_val("tbl_err",  0, err_a,  tbl[i].exp_err);
            check_val("tbl_code", 0, code_a, tbl[i].exp_code);
            if (tbl[i].exp_done) begin
                check_val("tbl_vch",  0, vch_a,  tbl[i].exp_vch);
                check_val("tbl_last", 0, last_a, tbl[i].exp_last);
            end
        end

        // Reset in the middle of a VC0 packet discards it.
        send(1'b0, TYPE_HEAD, 1'b0);
        for (int i = 0; i < 5; i++) send(1'b0, TYPE_DATA, 1'b0);
        ivalid = 1'b0;
        #2;
        rst_ = 1'b0;
        #1;
        model_reset();
        check_output();
        check_val("rst_mid_cnt", 0, {pkt_a, flit_a, tog_a}, 0);
        @(posedge clk);
        #1;
        check_output();
        rst_ = 1'b1;
        send(1'b0, TYPE_DATA, 1'b0);
        check_val("post_rst_err",  0, err_a,  1);
        check_val("post_rst_code", 0, code_a, 1);
        send(1'b0, TYPE_TAIL, 1'b0);
        check_val("post_rst_done", 0, done_a, 0);

        // clr coincident with a good TAIL while pkt_cnt is 3.
        idle_cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, TYPE_HEAD, 1'b0);
            send(1'b0, TYPE_TAIL, 1'b0);
        end
        check_val("clr_pre_cnt", 0, pkt_a, 3);
        send(1'b0, TYPE_HEAD, 1'b0);
        send(1'b0, TYPE_DATA, 1'b0);
        send(1'b0, TYPE_DATA, 1'b0);
        send(1'b0, TYPE_TAIL, 1'b1);
        check_val("clr_cnt",  0, pkt_a,  0);
        check_val("clr_done", 0, done_a, 1);
        check_val("clr_last", 0, last_a, 2);
        check_val("clr_err",  0, err_a,  0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [1:0] t;
            r = int'($urandom_range(0, 9));
            t = (r == 0) ? TYPE_NONE : (r <= 2) ? TYPE_HEAD : (r <= 4) ? TYPE_TAIL : TYPE_DATA;
            apply_stimulus($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), make_flit(t),
                           $urandom_range(0, 9) < 9, $urandom_range(0, 49) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flit_sink.md
# flit_sink

Cycle-accurate receive-side monitor for the router's flit interface. Sits on the output of a router mux (odata/ovalid/ovch) in characterization and regression benches. Reconstructs packets per virtual channel from HEAD/DATA/TAIL flits, counts packets and flits, and checks framing. It also accumulates bit-toggle activity on the data bus inside a measurement window, as a hardware equivalent of the switching-activity dump used for energy characterization.

## Interface
- FLIT_W, 66: flit width; bits [FLIT_W-1:FLIT_W-2] are the type field, the rest is payload.
- VCH_W, 1: virtual-channel id width; NVC = 2**VCH_W independent packet trackers.
- LEN_W, 8: payload-length counter width.
- MAX_LEN, 255: maximum DATA flits per packet; must be < 2**LEN_W.
- clk  in  1  clock; all state updates on rising edge.
- rst_  in  1  asynchronous, active-low reset.
- idata  in  FLIT_W  flit from mux odata.
- ivalid  in  1  flit valid (no backpressure; a valid flit is consumed every cycle).
- ivch  in  VCH_W  virtual channel of idata.
- en  in  1  measurement window; counters advance only while high.
- clr  in  1  synchronous clear of counters and error state.
- pkt_done  out  1  one-cycle pulse when a well-formed TAIL is accepted.
- pkt_vch  out  VCH_W  VC of the packet flagged by pkt_done.
- last_len  out  LEN_W  DATA-flit count of the last completed packet.
- pkt_cnt  out  16  completed packets, saturating.
- flit_cnt  out  32  valid flits seen, saturating.
- toggle_sum  out  32  accumulated Hamming distance of idata, saturating.
- err  out  1  sticky error flag.
- err_code  out  3  code of the first error since reset/clr.

## Operation
- Type codes are 2'b00 NONE, 2'b01 HEAD, 2'b10 TAIL, 2'b11 DATA.
- Per-VC FSM with states IDLE and BODY, plus a LEN_W length counter. All VC FSMs reset to IDLE.
- IDLE, valid HEAD: go to BODY, len := 0.
- BODY, valid DATA: len := len+1. If len would exceed MAX_LEN, raise LEN (3'd4), stay in BODY, and saturate len.
- BODY, valid TAIL: go to IDLE, pulse pkt_done, set pkt_vch := ivch, set last_len := len, and increment pkt_cnt.
- Framing errors:
  - IDLE with valid DATA or TAIL: raise ORPHAN (3'd1); state unchanged.
  - BODY with valid HEAD: raise NESTED (3'd2); len restarts at 0 and the FSM stays in BODY.
  - Valid NONE in any state: raise NULL (3'd3); state unchanged.
- err_code holds the first error raised; later errors do not overwrite it. err stays set until clr or reset.
- Only the FSM selected by ivch is affected in a given cycle.
- Toggle accounting:
  - prev_data register captures idata every cycle, regardless of ivalid or en.
  - While en=1: toggle_sum += popcount(idata ^ prev_data).
- flit_cnt increments on every valid flit while en=1, error flits included.
- pkt_cnt increments only while en=1. The FSMs, pkt_done and last_len operate regardless of en.
- clr zeroes pkt_cnt, flit_cnt, toggle_sum, err and err_code. It does not touch the FSMs, last_len or prev_data. When clr and an event occur in the same cycle, clr wins for the counters and error state.

## Timing
- All outputs are registered. The effect of the flit sampled at edge N is visible after edge N, i.e. 1-cycle latency.
- pkt_done is high for exactly one cycle, the cycle after the TAIL is sampled.
- Back-to-back packets (TAIL followed immediately by HEAD on the same VC) are legal and produce no error.
- Interleaved VCs are tracked independently.
- Reset (asynchronous assert, synchronous deassert) sets every output to 0, all FSMs to IDLE, all len counters to 0, and prev_data to 0.
- Reset mid-packet: the packet is discarded. The next flit on that VC must be a HEAD, otherwise ORPHAN is raised.
- Saturation: counters hold at all-ones and never wrap.
- Popcount is computed combinationally into a registered adder with a single-cycle path. FLIT_W up to 128 must close timing at 400 MHz.

## Structure
- The shared router package/define file holds TYPE_NONE/HEAD/TAIL/DATA, the err_code enumeration, and FLIT_W/VCH_W defaults.
- Sub-module flit_vc_tracker, instantiated NVC times, contains one VC's FSM, length counter and per-VC error detect. Top-level flit_sink handles arbitration of error priority, the counters and the toggle accumulator.

## Test plan
- Packet on VC1: HEAD, then 20 DATA, then TAIL, with en=1 -> pkt_done pulses one cycle after TAIL with pkt_vch=1; last_len=20, pkt_cnt=1, flit_cnt=22, err=0.
- Toggle check: idata alternates all-zeros and all-ones (66 bits) for 4 cycles with en=1 -> toggle_sum=264. Same stimulus with en=0 -> toggle_sum stays 0.
- DATA on idle VC0 -> err=1, err_code=1. A following HEAD inside a VC0 packet -> err_code remains 1.
- MAX_LEN=16, HEAD, 20 DATA, TAIL -> err_code=4, last_len=16, pkt_done still pulses.
- Reset asserted after HEAD and 5 DATA; released, then DATA, TAIL -> all outputs 0 during reset, then err_code=1 and no pkt_done.
- clr in the same cycle as a valid TAIL with pkt_cnt=3 -> pkt_cnt=0, pkt_done pulses, last_len updated, err=0.
